// File: rtl/mc_control_fsm_pkg.sv
// Shared RISC-V multicycle control definitions: opcodes, state encoding and
// datapath select encodings used by the control FSM and its bench.
package mc_control_fsm_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait counter: counts consecutive mem_ready=0 cycles in a memory
// state and flags the cycle in which the count reaches MEM_TIMEOUT.
module mc_wait_counter #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_en_i,
    input  logic mem_ready_i,
    output logic timeout_hit_o
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       stalled;

    assign stalled = wait_en_i && !mem_ready_i;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Outside a stall the count is held at zero, so every entry into a
    // memory state starts from a cleared counter.
    always_comb begin
        cnt_d = 8'd0;
        if (stalled) cnt_d = cnt_inc;
    end

    assign timeout_hit_o = stalled && (cnt_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM (Moore) with memory-wait timeout and sticky
// illegal/timeout fault flags.
//  FETCH/DECODE: instr fetch, decode | MEMADR/MEMREAD/MEMWB/MEMWRITE: ld/st
//  EXECR/EXECI/ALUWB: ALU ops | BEQ, JAL, LUI, AUIPC | TRAP: fault, until reset
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter bit          EXT_OPS     = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   timeout_q, timeout_d;
    logic   tmo_hit;

    mc_wait_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk          (clk),
        .rst_n        (rst_n),
        .wait_en_i    (is_wait_state(state_q)),
        .mem_ready_i  (mem_ready),
        .timeout_hit_o(tmo_hit)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        PCUpdate  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
                else if (tmo_hit) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_OP:              state_d = S_EXECR;
                    OPC_OP_IMM:          state_d = S_EXECI;
                    OPC_BRANCH:          state_d = S_BEQ;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_LUI:             state_d = EXT_OPS ? S_LUI : S_TRAP;
                    OPC_AUIPC:           state_d = EXT_OPS ? S_AUIPC : S_TRAP;
                    default:             state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) illegal_d = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = (state_q == S_MEMWRITE);
                if (mem_ready) state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
                else if (tmo_hit) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_SUB;
                Branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI, S_AUIPC: begin
                ALUSrcA = (state_q == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus random opcode/handshake
// traffic checked against an instruction-path reference model.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, mem_ready;
    logic [6:0] op;
    logic       PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic       illegal, timeout;
    logic [3:0] state;

    logic       rst0_n, mem_ready0;
    logic [6:0] op0;
    logic       PCUpdate0, IRWrite0, RegWrite0, MemWrite0, Branch0, AdrSrc0;
    logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0;
    logic       illegal0, timeout0;
    logic [3:0] state0;

    mc_control_fsm #(.EXT_OPS(1'b1), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCUpdate(PCUpdate), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Branch(Branch), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout), .state(state)
    );

    mc_control_fsm #(.EXT_OPS(1'b0), .MEM_TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst_n(rst0_n), .op(op0), .mem_ready(mem_ready0),
        .PCUpdate(PCUpdate0), .IRWrite(IRWrite0), .RegWrite(RegWrite0),
        .MemWrite(MemWrite0), .Branch(Branch0), .AdrSrc(AdrSrc0),
        .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
        .ALUOp(ALUOp0), .illegal(illegal0), .timeout(timeout0), .state(state0)
    );

    logic [13:0] obs_ctrl;
    assign obs_ctrl = {PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

    int n_pass = 0;
    int n_total = 0;

    // Reference model: each instruction is a fixed list of states after FETCH.
    state_e m_state;
    state_e m_path[$];
    int     m_waits;
    bit     m_illegal, m_timeout;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] exp_ctrl(input state_e s, input logic mr);
        logic pcu, irw, rw, mw, br, adr;
        logic [1:0] res, sa, sb, aop;
        {pcu, irw, rw, mw, br, adr} = 6'b0;
        {res, sa, sb, aop} = 8'b0;
        case (s)
            S_FETCH:    begin sb = 2'b10; res = 2'b10; irw = mr; pcu = mr; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  adr = 1'b1;
            S_MEMWB:    begin res = 2'b01; rw = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            S_EXECR:    begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            S_ALUWB:    rw = 1'b1;
            S_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
            S_LUI:      begin sa = 2'b11; sb = 2'b01; end
            S_AUIPC:    begin sa = 2'b01; sb = 2'b01; end
            default:    ;
        endcase
        return {pcu, irw, rw, mw, br, adr, res, sa, sb, aop};
    endfunction

    task automatic build_path(input logic [6:0] opc);
        m_path.delete();
        m_path.push_back(S_DECODE);
        case (opc)
            7'b0000011: begin m_path.push_back(S_MEMADR); m_path.push_back(S_MEMREAD); m_path.push_back(S_MEMWB); end
            7'b0100011: begin m_path.push_back(S_MEMADR); m_path.push_back(S_MEMWRITE); end
            7'b0110011: begin m_path.push_back(S_EXECR); m_path.push_back(S_ALUWB); end
            7'b0010011: begin m_path.push_back(S_EXECI); m_path.push_back(S_ALUWB); end
            7'b1100011: m_path.push_back(S_BEQ);
            7'b1101111: begin m_path.push_back(S_JAL); m_path.push_back(S_ALUWB); end
            7'b0110111: begin m_path.push_back(S_LUI); m_path.push_back(S_ALUWB); end
            7'b0010111: begin m_path.push_back(S_AUIPC); m_path.push_back(S_ALUWB); end
            default:    m_path.push_back(S_TRAP);
        endcase
    endtask

    task automatic model_step(input logic mr);
        if (m_state == S_TRAP) return;
        if ((m_state == S_FETCH || m_state == S_MEMREAD || m_state == S_MEMWRITE) && !mr) begin
            m_waits++;
            if (m_waits == TMO) begin
                m_state   = S_TRAP;
                m_timeout = 1'b1;
                m_path.delete();
            end
            return;
        end
        m_waits = 0;
        if (m_state == S_FETCH) build_path(op);
        if (m_path.size() == 0) m_state = S_FETCH;
        else begin
            m_state = m_path.pop_front();
            if (m_state == S_TRAP) m_illegal = 1'b1;
        end
    endtask

    // Called at a falling edge: drive, check, then advance to the next falling edge.
    task automatic cycle(input logic mr);
        mem_ready = mr;
        #1;
        chk($sformatf("state(%s)", m_state.name()), 16'(state), 16'(m_state));
        chk($sformatf("ctrl(%s,mr=%0b)", m_state.name(), mr), 16'(obs_ctrl), 16'(exp_ctrl(m_state, mr)));
        chk($sformatf("flags(%s)", m_state.name()), 16'({illegal, timeout}), 16'({m_illegal, m_timeout}));
        model_step(mr);
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; outputs are checked before any clock edge.
    task automatic apply_reset();
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_state = S_FETCH; m_waits = 0; m_illegal = 1'b0; m_timeout = 1'b0;
        m_path.delete();
        chk("rst_state", 16'(state), 16'(S_FETCH));
        chk("rst_ctrl", 16'(obs_ctrl), 16'(exp_ctrl(S_FETCH, 1'b0)));
        chk("rst_flags", 16'({illegal, timeout}), 16'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input logic [6:0] opc, input int n);
        op = opc;
        repeat (n) cycle(1'b1);
    endtask

    logic [6:0] ops [9];
    int burst;

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b0110111, 7'b0010111, 7'b0000000};
        rst_n = 1'b1; rst0_n = 1'b0; mem_ready = 1'b1; op = OPC_OP;
        mem_ready0 = 1'b1; op0 = OPC_LUI;
        apply_reset();

        run_op(OPC_OP, 4);
        chk("rtype_latency", 16'(state), 16'(S_FETCH));

        op = OPC_LOAD;
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        repeat (3) cycle(1'b0);
        cycle(1'b1); cycle(1'b1);

        op = OPC_STORE;
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        repeat (TMO - 1) cycle(1'b0);
        cycle(1'b1);

        op = OPC_STORE;
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        repeat (TMO) cycle(1'b0);
        repeat (3) cycle(1'b1);
        chk("store_timeout_flag", 16'(timeout), 16'd1);
        chk("store_timeout_memwrite", 16'(MemWrite), 16'd0);
        apply_reset();

        run_op(OPC_LUI, 4);
        run_op(OPC_AUIPC, 4);
        run_op(OPC_OP_IMM, 4);
        run_op(OPC_BRANCH, 3);
        run_op(OPC_JAL, 4);
        run_op(OPC_STORE, 4);
        run_op(OPC_LOAD, 5);

        op = OPC_LOAD;
        cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0);
        apply_reset();

        repeat (TMO) cycle(1'b0);
        cycle(1'b1);
        apply_reset();

        run_op(7'b1111111, 3);
        chk("illegal_flag", 16'(illegal), 16'd1);
        apply_reset();

        burst = 0;
        for (int i = 0; i < 500; i++) begin
            if ((m_state == S_TRAP && $urandom_range(0, 2) == 0) || $urandom_range(0, 80) == 0)
                apply_reset();
            if (m_state == S_FETCH) begin
                if ($urandom_range(0, 9) == 0) op = 7'($urandom);
                else op = ops[$urandom_range(0, 8)];
            end
            if (burst == 0 && $urandom_range(0, 25) == 0) burst = int'($urandom_range(3, 5));
            if (burst > 0) begin
                burst--;
                cycle(1'b0);
            end else begin
                cycle(logic'($urandom_range(0, 3) != 0));
            end
        end

        rst0_n = 1'b1;
        @(negedge clk); #1;
        chk("ext0_decode", 16'(state0), 16'(S_DECODE));
        @(negedge clk); #1;
        chk("ext0_trap", 16'(state0), 16'(S_TRAP));
        chk("ext0_illegal", 16'({illegal0, timeout0}), 16'b10);
        chk("ext0_strobes", 16'({PCUpdate0, IRWrite0, RegWrite0, MemWrite0, Branch0}), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter EXT_OPS, default 1: 1 = LUI/AUIPC decoded; 0 = LUI/AUIPC treated as illegal.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready in any memory state, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 op  input  7  opcode field of the instruction register.
REQ-006 mem_ready  input  1  memory handshake; the current access completes in a cycle where mem_ready=1.
REQ-007 PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc  output  1 each  datapath strobes/selects.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  output  2 each  datapath mux selects and ALU class (ALUOp: 00 add, 01 sub/compare, 10 funct-decoded).
REQ-009 illegal, timeout  output  1 each  sticky fault flags.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 Moore FSM; every output SHALL be a function of state only, except IRWrite/PCUpdate/RegWrite(MEMWB excluded)/MemWrite, which SHALL also be qualified by mem_ready where noted.
REQ-012 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, AUIPC, TRAP.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready; -> DECODE when mem_ready, else hold.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: LOAD/STORE -> MEMADR, OP -> EXECR, OP_IMM -> EXECI, BRANCH -> BEQ, JAL -> JAL, LUI(0110111)/AUIPC(0010111) -> LUI/AUIPC if EXT_OPS=1, any other -> TRAP.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> MEMREAD if LOAD, MEMWRITE if STORE.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00; -> MEMWB when mem_ready, else hold.
REQ-017 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-018 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 while waiting; -> FETCH when mem_ready.
REQ-019 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB.
REQ-023 LUI: ALUSrcA=11 (zero), ALUSrcB=01, ALUOp=00 -> ALUWB; AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00 -> ALUWB.
REQ-024 All unlisted strobes SHALL be 0 and unlisted selects 00 in every state; no X outputs.
REQ-025 Wait counter (8 bits) SHALL clear on entry to FETCH/MEMREAD/MEMWRITE, increment each cycle mem_ready=0 there, and saturate.
REQ-026 When counter reaches MEM_TIMEOUT with mem_ready=0 -> TRAP, timeout=1; mem_ready=1 on that same cycle SHALL win (normal transition, no fault).
REQ-027 TRAP: all strobes 0; held until reset; illegal/timeout remain set.
REQ-028 Latency without wait: R/I-type 4 cycles, load 5, store 4, branch 3, JAL 4, LUI/AUIPC 4.

Reset
REQ-029 rst_n=0 SHALL force state=FETCH, counter=0, illegal=timeout=0 immediately, including mid-instruction; first fetch begins at first clk edge after release.

Structure
REQ-030 Opcode constants, state encoding and select encodings SHALL live in the shared riscv control package.
REQ-031 Single module with one sub-module: mc_wait_counter (counter + timeout compare).

Verification
REQ-032 op=0110011, mem_ready=1: FETCH->DECODE->EXECR->ALUWB->FETCH, RegWrite=1 only in ALUWB, ALUOp=10 in EXECR.
REQ-033 op=0000011, mem_ready low 3 cycles in MEMREAD: state holds 3 cycles, MEMWB RegWrite=1, ResultSrc=01, timeout=0.
REQ-034 MEM_TIMEOUT=4, mem_ready=0 in MEMWRITE: TRAP after 4 waits, timeout=1, MemWrite=0 thereafter.
REQ-035 EXT_OPS=0, op=0110111: DECODE->TRAP, illegal=1; EXT_OPS=1: LUI path, ALUSrcA=11.
REQ-036 rst_n pulsed low in MEMREAD: state=FETCH asynchronously, flags 0, all strobes 0.
REQ-037 op=1100011: BEQ state Branch=1, ALUOp=01, returns to FETCH after 3 cycles.
